// File: rtl/mem_arb_pkg.sv
// Shared types and requester IDs for the two-port memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_e;

    localparam logic CPU_ID = 1'b0;
    localparam logic DMA_ID = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way request picker; round-robin on a tie unless
// MEM_PORT_ARBITER_FIXED_PRIO_EN selects fixed CPU priority.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       winner,
    output logic       valid
);

`ifdef MEM_PORT_ARBITER_FIXED_PRIO_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

    // Winner selection: a lone requester wins, a tie is resolved by policy
    always_comb begin
        winner = CPU_ID;
        valid  = |req;
        if (req == 2'b11) begin
`ifdef MEM_PORT_ARBITER_FIXED_PRIO_EN
            winner = CPU_ID;
`else
            winner = ~last_grant;
`endif
        end else if (req[1]) begin
            winner = DMA_ID;
        end else begin
            winner = CPU_ID;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// CPU/DMA arbiter for a single-port synchronous memory with fixed read latency.
// Build option: MEM_PORT_ARBITER_FIXED_PRIO_EN (fixed CPU priority on ties).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);

    localparam logic [2:0] RD_LAT_C = 3'(RD_LAT);

    arb_state_e        state_r, state_s;
    logic [2:0]        lat_cnt_r, lat_cnt_s;
    logic              last_grant_r, last_grant_s;
    logic              owner_r, owner_s;
    logic              gnt0_r, gnt0_s, gnt1_r, gnt1_s;
    logic              rvalid0_r, rvalid0_s, rvalid1_r, rvalid1_s;
    logic [ADDR_W-1:0] mem_addr_r, mem_addr_s;
    logic [DATA_W-1:0] mem_wdata_r, mem_wdata_s;
    logic              mem_we_r, mem_we_s;
    logic              busy_r, busy_s;
    logic              pick_winner_s, pick_valid_s;

    rr_pick2 u_pick (
        .req        ({req1, req0}),
        .last_grant (last_grant_r),
        .winner     (pick_winner_s),
        .valid      (pick_valid_s)
    );

    // Next-state and next-output decode; all outputs are registered from these
    always_comb begin
        state_s      = state_r;
        lat_cnt_s    = lat_cnt_r;
        last_grant_s = last_grant_r;
        owner_s      = owner_r;
        mem_addr_s   = mem_addr_r;
        mem_wdata_s  = mem_wdata_r;
        mem_we_s     = 1'b0;
        gnt0_s       = 1'b0;
        gnt1_s       = 1'b0;
        rvalid0_s    = 1'b0;
        rvalid1_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (pick_valid_s) begin
                    state_s      = ISSUE;
                    owner_s      = pick_winner_s;
                    last_grant_s = pick_winner_s;
                    mem_addr_s   = (pick_winner_s == DMA_ID) ? addr1  : addr0;
                    mem_wdata_s  = (pick_winner_s == DMA_ID) ? wdata1 : wdata0;
                    mem_we_s     = (pick_winner_s == DMA_ID) ? we1    : we0;
                    gnt0_s       = (pick_winner_s == CPU_ID);
                    gnt1_s       = (pick_winner_s == DMA_ID);
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                // mem_we_r still holds the issued access type during ISSUE
                if (mem_we_r) begin
                    state_s = IDLE;
                end else begin
                    state_s   = WAIT;
                    lat_cnt_s = RD_LAT_C;
                    rvalid0_s = (RD_LAT_C == 3'd1) && (owner_r == CPU_ID);
                    rvalid1_s = (RD_LAT_C == 3'd1) && (owner_r == DMA_ID);
                end
            end
            WAIT: begin
                if (lat_cnt_r <= 3'd1) begin
                    state_s   = IDLE;
                    lat_cnt_s = 3'd0;
                end else begin
                    state_s   = WAIT;
                    lat_cnt_s = lat_cnt_r - 3'd1;
                    rvalid0_s = (lat_cnt_r == 3'd2) && (owner_r == CPU_ID);
                    rvalid1_s = (lat_cnt_r == 3'd2) && (owner_r == DMA_ID);
                end
            end
            default: begin
                state_s   = IDLE;
                lat_cnt_s = 3'd0;
            end
        endcase
        busy_s = (state_s != IDLE);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r      <= IDLE;
            lat_cnt_r    <= 3'd0;
            last_grant_r <= DMA_ID;
            owner_r      <= CPU_ID;
            gnt0_r       <= 1'b0;
            gnt1_r       <= 1'b0;
            rvalid0_r    <= 1'b0;
            rvalid1_r    <= 1'b0;
            mem_addr_r   <= '0;
            mem_wdata_r  <= '0;
            mem_we_r     <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            lat_cnt_r    <= lat_cnt_s;
            last_grant_r <= last_grant_s;
            owner_r      <= owner_s;
            gnt0_r       <= gnt0_s;
            gnt1_r       <= gnt1_s;
            rvalid0_r    <= rvalid0_s;
            rvalid1_r    <= rvalid1_s;
            mem_addr_r   <= mem_addr_s;
            mem_wdata_r  <= mem_wdata_s;
            mem_we_r     <= mem_we_s;
            busy_r       <= busy_s;
        end
    end

    assign gnt0      = gnt0_r;
    assign gnt1      = gnt1_r;
    assign rvalid0   = rvalid0_r;
    assign rvalid1   = rvalid1_r;
    assign rdata0    = mem_rdata;
    assign rdata1    = mem_rdata;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign mem_we    = mem_we_r;
    assign busy      = busy_r;
    assign owner     = owner_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed-vector bench for mem_port_arbiter with RD_LAT = 2 and a behavioural memory.
module tb_mem_port_arbiter;

    localparam int RD_LAT = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req0, req1, we0, we1;
    logic [15:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1, mem_we, busy, owner;
    logic [15:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
    );

    // Synchronous memory: one cycle array read plus one output stage = RD_LAT 2
    logic [15:0] mem [65536];
    logic [15:0] pipe0, pipe1;
    always @(posedge clk) begin
        pipe0 <= mem[mem_addr];
        pipe1 <= pipe0;
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = pipe1;

    typedef struct {
        logic r0, w0; logic [15:0] a0, d0;
        logic r1, w1; logic [15:0] a1, d1;
        logic g0, g1, v0, v1, we, bsy, own;
        logic [15:0] maddr, mwd, rd;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r0, input logic w0, input logic [15:0] a0, input logic [15:0] d0,
                         input logic r1, input logic w1, input logic [15:0] a1, input logic [15:0] d1);
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One reset edge; returns at the start of the first post-reset cycle
    task automatic do_reset();
        drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        reset_n = 1'b0;
        next_cycle();
        reset_n = 1'b1;
    endtask

    int gseq [16];
    int ng;
    int last_id;
    int exp_id;

    initial begin
        tbl[0]  = '{1'b0,1'b0,16'h0000,16'h0000, 1'b1,1'b1,16'h0042,16'h1234, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 16'h0000,16'h0000,16'h0000};
        tbl[1]  = '{1'b0,1'b0,16'h0000,16'h0000, 1'b1,1'b1,16'h0042,16'h1234, 1'b0,1'b1,1'b0,1'b0,1'b1,1'b1,1'b1, 16'h0042,16'h1234,16'h0000};
        tbl[2]  = '{1'b0,1'b0,16'h0000,16'h0000, 1'b0,1'b0,16'h0000,16'h0000, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 16'h0042,16'h1234,16'h0000};
        tbl[3]  = '{1'b1,1'b1,16'h0010,16'hBEEF, 1'b0,1'b0,16'h0000,16'h0000, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 16'h0042,16'h1234,16'h0000};
        tbl[4]  = '{1'b1,1'b1,16'h0010,16'hBEEF, 1'b0,1'b0,16'h0000,16'h0000, 1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0, 16'h0010,16'hBEEF,16'h0000};
        tbl[5]  = '{1'b0,1'b0,16'h0000,16'h0000, 1'b0,1'b0,16'h0000,16'h0000, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 16'h0010,16'hBEEF,16'h0000};
        tbl[6]  = '{1'b0,1'b0,16'h0000,16'h0000, 1'b1,1'b0,16'h0042,16'h0000, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 16'h0010,16'hBEEF,16'h0000};
        tbl[7]  = '{1'b0,1'b0,16'h0000,16'h0000, 1'b1,1'b0,16'h0042,16'h0000, 1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b1, 16'h0042,16'h0000,16'h0000};
        tbl[8]  = '{1'b0,1'b0,16'h0000,16'h0000, 1'b0,1'b0,16'h0000,16'h0000, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1, 16'h0042,16'h0000,16'h0000};
        tbl[9]  = '{1'b0,1'b0,16'h0000,16'h0000, 1'b0,1'b0,16'h0000,16'h0000, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b1, 16'h0042,16'h0000,16'h1234};
        tbl[10] = '{1'b1,1'b0,16'h0010,16'h0000, 1'b0,1'b0,16'h0000,16'h0000, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 16'h0042,16'h0000,16'h0000};
        tbl[11] = '{1'b1,1'b0,16'h0010,16'h0000, 1'b0,1'b0,16'h0000,16'h0000, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 16'h0010,16'h0000,16'h0000};
        tbl[12] = '{1'b0,1'b0,16'h0000,16'h0000, 1'b0,1'b0,16'h0000,16'h0000, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 16'h0010,16'h0000,16'h0000};
        tbl[13] = '{1'b0,1'b0,16'h0000,16'h0000, 1'b0,1'b0,16'h0000,16'h0000, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0, 16'h0010,16'h0000,16'hBEEF};
        tbl[14] = '{1'b0,1'b0,16'h0000,16'h0000, 1'b0,1'b0,16'h0000,16'h0000, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 16'h0010,16'h0000,16'h0000};

        // Reset state
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt",    {30'd0, gnt1, gnt0}, 32'd0);
        chk("rst_rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_addr",   {16'd0, mem_addr}, 32'd0);
        chk("rst_wdata",  {16'd0, mem_wdata}, 32'd0);
        chk("rst_busy",   {31'd0, busy}, 32'd0);
        chk("rst_owner",  {31'd0, owner}, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Directed single-requester writes and reads
        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].r0, tbl[i].w0, tbl[i].a0, tbl[i].d0, tbl[i].r1, tbl[i].w1, tbl[i].a1, tbl[i].d1);
            @(negedge clk);
            chk($sformatf("v%0d_gnt0", i),    {31'd0, gnt0},    {31'd0, tbl[i].g0});
            chk($sformatf("v%0d_gnt1", i),    {31'd0, gnt1},    {31'd0, tbl[i].g1});
            chk($sformatf("v%0d_rvalid0", i), {31'd0, rvalid0}, {31'd0, tbl[i].v0});
            chk($sformatf("v%0d_rvalid1", i), {31'd0, rvalid1}, {31'd0, tbl[i].v1});
            chk($sformatf("v%0d_mem_we", i),  {31'd0, mem_we},  {31'd0, tbl[i].we});
            chk($sformatf("v%0d_busy", i),    {31'd0, busy},    {31'd0, tbl[i].bsy});
            chk($sformatf("v%0d_owner", i),   {31'd0, owner},   {31'd0, tbl[i].own});
            chk($sformatf("v%0d_mem_addr", i),  {16'd0, mem_addr},  {16'd0, tbl[i].maddr});
            chk($sformatf("v%0d_mem_wdata", i), {16'd0, mem_wdata}, {16'd0, tbl[i].mwd});
            if (tbl[i].v0 || tbl[i].v1) begin
                chk($sformatf("v%0d_rdata0", i), {16'd0, rdata0}, {16'd0, tbl[i].rd});
                chk($sformatf("v%0d_rdata1", i), {16'd0, rdata1}, {16'd0, tbl[i].rd});
            end
            next_cycle();
        end

        // Tie from reset: both reads held continuously
        do_reset();
        ng = 0;
        last_id = -1;
        drive(1'b1, 1'b0, 16'h0010, 16'h0, 1'b1, 1'b0, 16'h0042, 16'h0);
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            chk("tie_no_double_gnt", {31'd0, gnt0 & gnt1}, 32'd0);
            if (rvalid0) chk("tie_rvalid0_owner", 32'(last_id), 32'd0);
            if (rvalid1) chk("tie_rvalid1_owner", 32'(last_id), 32'd1);
            if (gnt0 && ng < 16) begin gseq[ng] = 0; ng++; last_id = 0; end
            if (gnt1 && ng < 16) begin gseq[ng] = 1; ng++; last_id = 1; end
            next_cycle();
        end
        chk("tie_grant_count", 32'(ng), 32'd5);
        for (int i = 0; i < ng; i++) begin
`ifdef MEM_PORT_ARBITER_FIXED_PRIO_EN
            exp_id = 0;
`else
            exp_id = i % 2;
`endif
            chk($sformatf("tie_grant%0d", i), 32'(gseq[i]), 32'(exp_id));
        end

        // Late DMA request during a CPU read's WAIT
        do_reset();
        for (int c = 0; c < 8; c++) begin
            if (c < 2)
                drive(1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
            else if (c < 6)
                drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h0042, 16'h0);
            else
                drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
            @(negedge clk);
            chk($sformatf("late_c%0d_gnt0", c),    {31'd0, gnt0},    {31'd0, c == 1});
            chk($sformatf("late_c%0d_gnt1", c),    {31'd0, gnt1},    {31'd0, c == 5});
            chk($sformatf("late_c%0d_rvalid0", c), {31'd0, rvalid0}, {31'd0, c == 3});
            chk($sformatf("late_c%0d_rvalid1", c), {31'd0, rvalid1}, {31'd0, c == 7});
            next_cycle();
        end

        // Reset asserted for one cycle during WAIT
        do_reset();
        drive(1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        next_cycle();
        @(negedge clk);
        chk("rstw_gnt0", {31'd0, gnt0}, 32'd1);
        next_cycle();
        drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        reset_n = 1'b0;
        next_cycle();
        reset_n = 1'b1;
        drive(1'b1, 1'b0, 16'h0010, 16'h0, 1'b1, 1'b0, 16'h0042, 16'h0);
        @(negedge clk);
        chk("rstw_busy",     {31'd0, busy},   32'd0);
        chk("rstw_mem_we",   {31'd0, mem_we}, 32'd0);
        chk("rstw_mem_addr", {16'd0, mem_addr}, 32'd0);
        chk("rstw_owner",    {31'd0, owner},  32'd0);
        chk("rstw_rvalid_c3", {30'd0, rvalid1, rvalid0}, 32'd0);
        next_cycle();
        @(negedge clk);
        chk("rstw_tie_gnt", {30'd0, gnt1, gnt0}, 32'd1);
        chk("rstw_rvalid_c4", {30'd0, rvalid1, rvalid0}, 32'd0);
        next_cycle();
        drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        @(negedge clk);
        chk("rstw_rvalid_c5", {30'd0, rvalid1, rvalid0}, 32'd0);
        next_cycle();
        @(negedge clk);
        chk("rstw_tie_rvalid0", {30'd0, rvalid1, rvalid0}, 32'd1);
        repeat (3) next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter sharing the processor's single-port synchronous data/instruction memory between the CPU (ADDR/DOUT/W path) and a DMA/program-loader master. It serialises accesses with a request/grant handshake, drives the registered memory address, data and write-enable, and returns read data with a valid pulse after the memory's fixed read latency. Sits between both masters and the memory macro.

## Interface
- ADDR_W, 16: memory address width
- DATA_W, 16: memory data width
- RD_LAT, 1: memory read latency in cycles, from mem_addr registered to mem_rdata valid; legal range 1..7

- clk  input  1  clock
- reset_n  input  1  synchronous, active-low reset
- req0 / req1  input  1  access request, CPU (0) / DMA (1)
- we0 / we1  input  1  1 = write, 0 = read; qualified by reqN
- addr0 / addr1  input  ADDR_W  access address
- wdata0 / wdata1  input  DATA_W  write data
- gnt0 / gnt1  output  1  one-cycle pulse: access issued to memory this cycle
- rvalid0 / rvalid1  output  1  one-cycle pulse: read data valid on rdataN
- rdata0 / rdata1  output  DATA_W  read data, equals mem_rdata; meaningful only with rvalidN
- mem_addr  output  ADDR_W  registered memory address
- mem_wdata  output  DATA_W  registered memory write data
- mem_we  output  1  registered memory write enable
- mem_rdata  input  DATA_W  memory read data
- busy  output  1  high in any state other than IDLE
- owner  output  1  ID of the requester currently or last served

## Operation
- States: IDLE, ISSUE, WAIT.
- IDLE: reqN sampled only here. No request → stay. Any request → pick winner, load mem_addr/mem_wdata/mem_we from winner, go to ISSUE.
- Pick: single request wins. Both requesting → round-robin: winner is the ID not equal to last_grant; last_grant updated to winner.
- ISSUE (one cycle): gntN = 1 for winner; mem_we = winner's we. Write → IDLE. Read → WAIT with lat_cnt = RD_LAT.
- WAIT: lat_cnt decrements each cycle; in the cycle lat_cnt == 1, rvalidN = 1 for owner and next state is IDLE.
- Requester holds reqN, weN, addrN and wdataN stable until gntN is high, and clears reqN at that clock edge; a reqN still high in the following IDLE cycle is a new access.
- Requests arriving in ISSUE/WAIT wait for IDLE; none are dropped while reqN is held.
- mem_we is forced 0 outside ISSUE; mem_addr/mem_wdata hold their last value.
- rdataN = mem_rdata combinationally for both N; only rvalidN distinguishes the consumer.

## Timing
- Reset values: state IDLE, gnt0/1 = 0, rvalid0/1 = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, busy = 0, owner = 0, last_grant = 1 (first tie goes to CPU), lat_cnt = 0.
- Write: req in cycle N → gnt and mem_we in N+1 → IDLE in N+2. One write per 2 cycles.
- Read: req in N → gnt in N+1 → rvalid in N+1+RD_LAT → IDLE in N+2+RD_LAT.
- Reset mid-operation: at the reset edge, all outputs take reset values; an in-flight read is abandoned and produces no rvalid.
- Both requests present continuously: grants strictly alternate 0,1,0,1….

## Configuration
- MEM_PORT_ARBITER_FIXED_PRIO_EN defined: fixed priority; CPU (0) always wins a tie and last_grant is unused (DMA can starve).
- Not defined: round-robin as specified above.

## Structure
- Package mem_arb_pkg: state enum (IDLE, ISSUE, WAIT), requester IDs CPU_ID = 0, DMA_ID = 1.
- Sub-module rr_pick2: combinational 2-way picker (req[1:0], last_grant → winner, valid), with the fixed-priority macro applied inside it.

## Test plan
- CPU write only, RD_LAT = 1: req0 = 1, we0 = 1, addr0 = 0x0010, wdata0 = 0xBEEF at cycle 0 → gnt0, mem_we = 1, mem_addr = 0x0010, mem_wdata = 0xBEEF in cycle 1; busy = 0 in cycle 2.
- DMA read, RD_LAT = 2: req1 read addr1 = 0x0042 at cycle 0, memory returns 0x1234 → gnt1 in cycle 1; rvalid1 = 1 with rdata1 = 0x1234 in cycle 3; rvalid0 stays 0.
- Tie from reset: req0 and req1 both reads held → grants in order 0,1,0,1; no two consecutive grants go to the same ID.
- Same tie with MEM_PORT_ARBITER_FIXED_PRIO_EN defined → every grant is gnt0 while req0 stays high.
- Late request: req1 raised during a CPU read's WAIT → gnt1 only in the cycle after return to IDLE, never overlapping rvalid0.
- Reset during WAIT: reset_n = 0 for one cycle → no rvalid, state IDLE, mem_we = 0; next tie is granted to CPU.
